// File: rtl/m_st7789_sched.sv
// m_st7789_sched
// Byte-level scheduler for the ST7789 SPI link. Drives the single byte sender
// with, in order: the panel reset pulse and init command list, then a
// continuous frame stream (window commands + RGB565 pixels from vmem), with an
// optional MADCTL update injected only between frames.
//
// Ports
//   w_clk         system clock
//   w_rst         synchronous active-high reset
//   w_busy        byte sender busy
//   w_en          one-cycle byte-send strobe
//   w_data        {DC, byte}; DC=0 command, DC=1 data; held between issues
//   w_raddr       vmem read address {y, x}
//   w_rdata       vmem pixel, valid 2 cycles after w_raddr changes
//   w_RES         panel reset, active-low
//   w_cfg_req     MADCTL update request (level, held until w_cfg_ack)
//   w_cfg_val     MADCTL parameter byte
//   w_cfg_ack     pulses in the cycle the MADCTL parameter byte is issued
//   w_init_done   high once the init list has been sent
//   w_frame_done  one-cycle pulse per completed frame
//
// PIX_W / PIX_H default to the 240x240 panel; they also set the window end
// bytes of the per-frame window list.
module m_st7789_sched #(
    parameter int unsigned RST_LO_START = 10000,
    parameter int unsigned RST_LO_END   = 20000,
    parameter int unsigned INIT_START   = 30000,
    parameter int unsigned INIT_GAP     = 2048,
    parameter int unsigned PIX_W        = 240,
    parameter int unsigned PIX_H        = 240
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_busy,
    output logic        w_en,
    output logic [8:0]  w_data,
    output logic [15:0] w_raddr,
    input  logic [15:0] w_rdata,
    output logic        w_RES,
    input  logic        w_cfg_req,
    input  logic [7:0]  w_cfg_val,
    output logic        w_cfg_ack,
    output logic        w_init_done,
    output logic        w_frame_done
);

    typedef enum logic [2:0] {
        S_RST,
        S_INIT,
        S_WIN,
        S_PIX,
        S_FDONE,
        S_CFG
    } state_t;

    localparam logic [7:0] X_END = 8'(PIX_W - 1);
    localparam logic [7:0] Y_END = 8'(PIX_H - 1);

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n, cnt_inc;
    logic [4:0]  idx, idx_n;
    logic        lo, lo_n;
    logic [1:0]  px_wait, px_wait_n;
    logic [7:0]  x, x_n, y, y_n;
    logic [7:0]  cfg, cfg_n;
    logic        en_q;
    logic [8:0]  data_q;
    logic        init_done, init_done_n;
    logic        want;
    logic [8:0]  cur_byte;

    function automatic logic [8:0] init_byte(input logic [4:0] i);
        case (i)
            5'd0:  return 9'h001;
            5'd1:  return 9'h011;
            5'd2:  return 9'h03A;
            5'd3:  return 9'h155;
            5'd4:  return 9'h036;
            5'd5:  return 9'h100;
            5'd6:  return 9'h02A;
            5'd10: return 9'h1EF;
            5'd11: return 9'h02B;
            5'd15: return 9'h1EF;
            5'd16: return 9'h021;
            5'd17: return 9'h013;
            5'd18: return 9'h029;
            default: return 9'h100;
        endcase
    endfunction

    function automatic logic [8:0] win_byte(input logic [4:0] i);
        case (i)
            5'd0:  return 9'h02A;
            5'd4:  return {1'b1, X_END};
            5'd5:  return 9'h02B;
            5'd9:  return {1'b1, Y_END};
            5'd10: return 9'h02C;
            default: return 9'h100;
        endcase
    endfunction

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state     <= S_RST;
            cnt       <= '0;
            idx       <= '0;
            lo        <= 1'b0;
            px_wait   <= '0;
            x         <= '0;
            y         <= '0;
            cfg       <= '0;
            en_q      <= 1'b0;
            data_q    <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            lo        <= lo_n;
            px_wait   <= px_wait_n;
            x         <= x_n;
            y         <= y_n;
            cfg       <= cfg_n;
            en_q      <= w_en;
            data_q    <= w_data;
            init_done <= init_done_n;
        end
    end

    always_comb begin
        cnt_inc     = (cnt == '1) ? cnt : cnt + 32'd1;
        want        = 1'b0;
        cur_byte    = data_q;
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        lo_n        = lo;
        px_wait_n   = (px_wait != '0) ? px_wait - 2'd1 : px_wait;
        x_n         = x;
        y_n         = y;
        cfg_n       = cfg;
        init_done_n = init_done;

        // Byte source for the current state; issue is gated below.
        case (state)
            S_INIT: begin
                want     = (cnt >= INIT_GAP);
                cur_byte = init_byte(idx);
            end
            S_WIN: begin
                want     = 1'b1;
                cur_byte = win_byte(idx);
            end
            S_PIX: begin
                // Hold off the high byte until the read pipeline has caught up
                // with the new address, independent of how fast the sender is.
                want     = (px_wait == '0);
                cur_byte = {1'b1, lo ? w_rdata[7:0] : w_rdata[15:8]};
            end
            S_CFG: begin
                want     = 1'b1;
                cur_byte = (idx == '0) ? 9'h036 : {1'b1, cfg};
            end
            default: ;
        endcase

        w_en         = want && !w_busy && !en_q;
        w_data       = w_en ? cur_byte : data_q;
        w_RES        = !((state == S_RST) && (cnt >= RST_LO_START) && (cnt < RST_LO_END));
        w_cfg_ack    = (state == S_CFG) && (idx != '0) && w_en;
        w_frame_done = (state == S_FDONE);
        w_init_done  = init_done;
        w_raddr      = {y, x};

        case (state)
            S_RST: begin
                cnt_n = cnt_inc;
                if (cnt >= INIT_START) state_n = S_INIT;
            end
            S_INIT: begin
                // Counter restarts at 1 on each issue so it measures the gap.
                cnt_n = w_en ? 32'd1 : cnt_inc;
                if (w_en) begin
                    if (idx == 5'd18) begin
                        idx_n       = '0;
                        init_done_n = 1'b1;
                        state_n     = S_WIN;
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
            end
            S_WIN: begin
                if (w_en) begin
                    if (idx == 5'd10) begin
                        idx_n   = '0;
                        lo_n    = 1'b0;
                        state_n = S_PIX;
                    end else begin
                        idx_n = idx + 5'd1;
                    end
                end
            end
            S_PIX: begin
                if (w_en) begin
                    if (!lo) begin
                        lo_n = 1'b1;
                    end else begin
                        lo_n      = 1'b0;
                        px_wait_n = 2'd3;
                        if (x == X_END) begin
                            x_n = '0;
                            if (y == Y_END) begin
                                y_n     = '0;
                                state_n = S_FDONE;
                            end else begin
                                y_n = y + 8'd1;
                            end
                        end else begin
                            x_n = x + 8'd1;
                        end
                    end
                end
            end
            S_FDONE: begin
                idx_n = '0;
                if (w_cfg_req) begin
                    cfg_n   = w_cfg_val;
                    state_n = S_CFG;
                end else begin
                    state_n = S_WIN;
                end
            end
            S_CFG: begin
                if (w_en) begin
                    if (idx == '0) begin
                        idx_n = 5'd1;
                    end else begin
                        idx_n   = '0;
                        state_n = S_WIN;
                    end
                end
            end
            default: state_n = S_RST;
        endcase
    end

endmodule

// File: tb/tb_m_st7789_sched.sv
// Bench for m_st7789_sched with shortened reset/init timing and an 8x4 frame.
// Stimulus pushes the expected byte stream into a queue; a negedge monitor
// pops and compares on every issued byte and checks the strobe flags.
module tb_m_st7789_sched;

    localparam int LO_START = 100;
    localparam int LO_END   = 200;
    localparam int I_START  = 300;
    localparam int I_GAP    = 64;
    localparam int PW       = 8;
    localparam int PH       = 4;
    localparam int FRAME_B  = 11 + 2 * PW * PH;

    logic        w_clk = 1'b0;
    logic        w_rst = 1'b1;
    logic        w_busy;
    logic        w_en;
    logic [8:0]  w_data;
    logic [15:0] w_raddr;
    logic [15:0] w_rdata;
    logic        w_RES;
    logic        w_cfg_req = 1'b0;
    logic [7:0]  w_cfg_val = 8'h00;
    logic        w_cfg_ack;
    logic        w_init_done;
    logic        w_frame_done;

    m_st7789_sched #(
        .RST_LO_START(LO_START),
        .RST_LO_END  (LO_END),
        .INIT_START  (I_START),
        .INIT_GAP    (I_GAP),
        .PIX_W       (PW),
        .PIX_H       (PH)
    ) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_busy      (w_busy),
        .w_en        (w_en),
        .w_data      (w_data),
        .w_raddr     (w_raddr),
        .w_rdata     (w_rdata),
        .w_RES       (w_RES),
        .w_cfg_req   (w_cfg_req),
        .w_cfg_val   (w_cfg_val),
        .w_cfg_ack   (w_cfg_ack),
        .w_init_done (w_init_done),
        .w_frame_done(w_frame_done)
    );

    always #5 w_clk = ~w_clk;

    // Sender model: busy for 19 cycles, or a random 1..200 in stall mode.
    bit stall_rand = 1'b0;
    int bcnt = 0;
    always @(posedge w_clk) begin
        if (w_rst) bcnt <= 0;
        else if (w_en) bcnt <= stall_rand ? int'($urandom_range(200, 1)) : 19;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign w_busy = (bcnt != 0);

    // vmem model: pixel value {y, x}, two-cycle read latency.
    logic [15:0] rd1, rd2;
    always @(posedge w_clk) begin
        rd1 <= w_raddr;
        rd2 <= rd1;
    end
    assign w_rdata = rd2;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0] d;
        bit ack;
        bit fd;
        bit id;
        bit gap;
    } exp_t;

    exp_t exp_q[$];
    logic [8:0] init_seq [19] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h100,
                                  9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
                                  9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF,
                                  9'h021, 9'h013, 9'h029};

    task automatic push(input logic [8:0] d, input bit ack, input bit fd, input bit id, input bit gap);
        exp_t e;
        e.d = d; e.ack = ack; e.fd = fd; e.id = id; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        for (int i = 0; i < 19; i++) push(init_seq[i], 1'b0, 1'b0, i == 18, i > 0);
    endtask

    task automatic push_frame();
        logic [8:0] w [11];
        w = '{9'h02A, 9'h100, 9'h100, 9'h100, {1'b1, 8'(PW - 1)},
              9'h02B, 9'h100, 9'h100, 9'h100, {1'b1, 8'(PH - 1)}, 9'h02C};
        for (int i = 0; i < 11; i++) push(w[i], 1'b0, 1'b0, 1'b0, 1'b0);
        for (int yy = 0; yy < PH; yy++)
            for (int xx = 0; xx < PW; xx++) begin
                push({1'b1, 8'(yy)}, 1'b0, 1'b0, 1'b0, 1'b0);
                push({1'b1, 8'(xx)}, 1'b0, (yy == PH - 1) && (xx == PW - 1), 1'b0, 1'b0);
            end
    endtask

    task automatic push_cfg(input logic [7:0] v);
        push(9'h036, 1'b0, 1'b0, 1'b0, 1'b0);
        push({1'b1, v}, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor
    bit   mon_en = 1'b0;
    int   n_popped = 0;
    int   cyc = 0;
    int   last_en_cyc = 0;
    bit   fd_pend = 1'b0;
    bit   id_level = 1'b0;
    bit   prev_en = 1'b0;
    bit   ack_exp, fd_next, id_next;
    exp_t e;

    always @(negedge w_clk) begin
        if (!mon_en) begin
            exp_q.delete();
            n_popped = 0;
            fd_pend  = 1'b0;
            id_level = 1'b0;
            prev_en  = 1'b0;
        end else begin
            ack_exp = 1'b0;
            fd_next = 1'b0;
            id_next = 1'b0;
            if (w_en) begin
                chk("en_while_busy", 32'(w_busy), 0);
                chk("en_back_to_back", 32'(prev_en), 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_byte: got %03h required none", w_data);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("byte%0d", n_popped), 32'(w_data), 32'(e.d));
                    if (e.gap) chk("init_gap", 32'((cyc - last_en_cyc) >= I_GAP), 1);
                    ack_exp = e.ack;
                    fd_next = e.fd;
                    id_next = e.id;
                    n_popped++;
                end
                last_en_cyc = cyc;
            end
            chk("cfg_ack", 32'(w_cfg_ack), 32'(ack_exp));
            chk("frame_done", 32'(w_frame_done), 32'(fd_pend));
            chk("init_done", 32'(w_init_done), 32'(id_level));
            fd_pend = fd_next;
            if (id_next) id_level = 1'b1;
            prev_en = w_en;
        end
        cyc++;
    end

    task automatic apply_reset();
        w_rst  = 1'b1;
        mon_en = 1'b0;
        @(posedge w_clk); #2;
        chk("rst_en", 32'(w_en), 0);
        chk("rst_RES", 32'(w_RES), 1);
        chk("rst_data", 32'(w_data), 0);
        chk("rst_raddr", 32'(w_raddr), 0);
        chk("rst_ack", 32'(w_cfg_ack), 0);
        chk("rst_init_done", 32'(w_init_done), 0);
        chk("rst_frame_done", 32'(w_frame_done), 0);
        w_rst = 1'b0;
    endtask

    // Called in the first cycle after reset release (counter 0).
    task automatic res_timeline();
        for (int c = 0; c < I_START; c++) begin
            chk($sformatf("RES_c%0d", c), 32'(w_RES), 32'(!(c >= LO_START && c < LO_END)));
            chk("no_early_en", 32'(w_en), 0);
            @(posedge w_clk); #2;
        end
    endtask

    task automatic wait_pop(input int target, input int limit, input string nm);
        int t = 0;
        while (n_popped < target && t < limit) begin
            @(posedge w_clk); #2;
            t++;
        end
        chk(nm, 32'(n_popped >= target), 1);
    endtask

    task automatic raise_cfg(input logic [7:0] v, input int limit);
        int t = 0;
        bit seen = 1'b0;
        w_cfg_req = 1'b1;
        w_cfg_val = v;
        while (!seen && t < limit) begin
            @(posedge w_clk); #2;
            t++;
            if (w_cfg_ack) seen = 1'b1;
        end
        chk("cfg_ack_seen", 32'(seen), 1);
        w_cfg_req = 1'b0;
        w_cfg_val = 8'($urandom);
    endtask

    initial begin
        logic [7:0] v;

        // Phase A: steady 19-cycle sender, MADCTL 60h requested mid-frame.
        apply_reset();
        push_init();
        push_frame();
        push_frame();
        push_cfg(8'h60);
        push_frame();
        push_frame();
        mon_en = 1'b1;
        res_timeline();
        wait_pop(19 + FRAME_B + 40, 20000, "reach_frame1_mid");
        raise_cfg(8'h60, 5000);
        // Reset mid-way through the pixels of the fourth frame.
        wait_pop(19 + 3 * FRAME_B + 2 + 11 + 20, 20000, "reach_frame3_pix");

        // Phase B: random stalls; same stream plus a random MADCTL value.
        apply_reset();
        stall_rand = 1'b1;
        v = 8'($urandom);
        push_init();
        push_frame();
        push_cfg(v);
        push_frame();
        mon_en = 1'b1;
        res_timeline();
        wait_pop(19 + 30, 30000, "reach_stall_frame0");
        raise_cfg(v, 40000);
        wait_pop(19 + 2 * FRAME_B + 2, 40000, "stall_stream_done");
        repeat (2) begin @(posedge w_clk); #2; end
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
